// File: rtl/grid_row_reader_if.sv
// Row stream from grid_row_reader to a consumer: one grid row per beat, valid/ready handshake.
`timescale 1ns/1ps
interface grid_row_reader_if #(
  parameter int unsigned ROW_WIDTH = 8,
  parameter int unsigned IDX_W     = 3
);
  logic [ROW_WIDTH-1:0] row_out;
  logic                 row_valid;
  logic                 row_ready;
  logic [IDX_W-1:0]     row_index;
  logic                 last_row;

  modport master (
    output row_out, row_valid, row_index, last_row,
    input  row_ready
  );

  modport slave (
    input  row_out, row_valid, row_index, last_row,
    output row_ready
  );
endinterface

// File: rtl/grid_row_reader.sv
// Snapshots the flattened grid word on request and streams it out one row per beat,
// so the consumer can read generation N while generation N+1 is being written.
`timescale 1ns/1ps
module grid_row_reader #(
  parameter int unsigned DATA_SIZE = 64,
  parameter int unsigned ROW_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_SIZE-1:0] grid_in,
  input  logic                 start,
  grid_row_reader_if.master    row,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned ROW_W_SAFE = (ROW_WIDTH == 0) ? 1 : ROW_WIDTH;
  localparam int unsigned ROWS_RAW   = DATA_SIZE / ROW_W_SAFE;
  localparam int unsigned ROWS       = (ROWS_RAW == 0) ? 1 : ROWS_RAW;
  localparam int unsigned IDX_W      = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS - 1);

  if (ROW_WIDTH == 0 || (DATA_SIZE % ROW_W_SAFE) != 0) begin : g_width_err
    $error("grid_row_reader: DATA_SIZE must be a nonzero integer multiple of ROW_WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                          state, state_nxt;
  logic [ROWS-1:0][ROW_W_SAFE-1:0] snapshot, snapshot_nxt;
  logic [IDX_W-1:0]                row_index, index_nxt;

  // State, snapshot and row pointer; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      snapshot  <= '0;
      row_index <= '0;
    end else begin
      state     <= state_nxt;
      snapshot  <= snapshot_nxt;
      row_index <= index_nxt;
    end
  end

  // Next-state logic; outputs decode only registered state, never start or row_ready.
  always_comb begin
    state_nxt     = state;
    snapshot_nxt  = snapshot;
    index_nxt     = row_index;
    row.row_valid = 1'b0;
    row.last_row  = 1'b0;
    row.row_index = row_index;
    row.row_out   = snapshot[row_index];
    busy          = 1'b0;
    done          = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          snapshot_nxt = grid_in;
          index_nxt    = '0;
          state_nxt    = SEND;
        end
      end
      SEND: begin
        row.row_valid = 1'b1;
        row.last_row  = (row_index == LAST_IDX);
        busy          = 1'b1;
        if (row.row_ready) begin
          if (row_index == LAST_IDX) begin
            state_nxt = DONE;
          end else begin
            index_nxt = row_index + IDX_W'(1);
          end
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        index_nxt = '0;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        index_nxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_grid_row_reader.sv
// Directed bench for grid_row_reader: 8-bit rows and 16-bit rows over a 64-bit grid word.
`timescale 1ns/1ps
module tb_grid_row_reader;

  localparam logic [63:0] G  = 64'h0807_0605_0403_0201;
  localparam logic [63:0] G2 = 64'h1817_1615_1413_1211;
  localparam logic [63:0] H  = 64'h1111_1111_1111_1111;
  localparam logic [63:0] W  = 64'hDDDD_CCCC_BBBB_AAAA;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] grid_in;
  logic        start8, start16;
  logic        busy8, done8, busy16, done16;
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;

  grid_row_reader_if #(.ROW_WIDTH(8),  .IDX_W(3)) r8  ();
  grid_row_reader_if #(.ROW_WIDTH(16), .IDX_W(2)) r16 ();

  grid_row_reader #(.DATA_SIZE(64), .ROW_WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .grid_in(grid_in), .start(start8),
    .row(r8), .busy(busy8), .done(done8)
  );

  grid_row_reader #(.DATA_SIZE(64), .ROW_WIDTH(16)) u16 (
    .clk(clk), .reset(reset), .grid_in(grid_in), .start(start16),
    .row(r16), .busy(busy16), .done(done16)
  );

  always #5 clk = ~clk;

  // Observed fields packed as {valid, busy, done, last, index, row}.
  wire [14:0] obs8  = {r8.row_valid, busy8, done8, r8.last_row, r8.row_index, r8.row_out};
  wire [21:0] obs16 = {r16.row_valid, busy16, done16, r16.last_row, r16.row_index, r16.row_out};

  function automatic logic [14:0] e8(input logic v, input logic b, input logic d, input logic l,
                                     input logic [2:0] idx, input logic [7:0] rw);
    return {v, b, d, l, idx, rw};
  endfunction

  function automatic logic [21:0] e16(input logic v, input logic b, input logic d, input logic l,
                                      input logic [1:0] idx, input logic [15:0] rw);
    return {v, b, d, l, idx, rw};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset;
    reset = 1'b1; start8 = 1'b0; start16 = 1'b0; grid_in = G;
    r8.row_ready = 1'b1; r16.row_ready = 1'b1;
    tick; tick;
    vectors++;
    if (obs8 !== e8(0, 0, 0, 0, 3'd0, 8'h00)) begin
      miscompares++; $display("FAIL reset8: got %h expected %h", obs8, e8(0, 0, 0, 0, 3'd0, 8'h00));
    end
    vectors++;
    if (obs16 !== e16(0, 0, 0, 0, 2'd0, 16'h0000)) begin
      miscompares++; $display("FAIL reset16: got %h expected %h", obs16, e16(0, 0, 0, 0, 2'd0, 16'h0000));
    end
    reset = 1'b0;
    tick;
  endtask

  task automatic test_stream;
    grid_in = G; r8.row_ready = 1'b1; start8 = 1'b1;
    cyc = 0; tick; start8 = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      vectors++;
      if (obs8 !== e8(1, 1, 0, c == 8, 3'(c - 1), 8'(c))) begin
        miscompares++;
        $display("FAIL stream beat %0d: got %h expected %h", c, obs8, e8(1, 1, 0, c == 8, 3'(c - 1), 8'(c)));
      end
      tick;
    end
    vectors++;
    if (obs8 !== e8(0, 1, 1, 0, 3'd7, 8'h08)) begin
      miscompares++; $display("FAIL stream done: got %h expected %h", obs8, e8(0, 1, 1, 0, 3'd7, 8'h08));
    end
    tick;
    vectors++;
    if (obs8 !== e8(0, 0, 0, 0, 3'd0, 8'h01)) begin
      miscompares++; $display("FAIL stream idle: got %h expected %h", obs8, e8(0, 0, 0, 0, 3'd0, 8'h01));
    end
  endtask

  task automatic test_backpressure;
    int k = 0;
    int stalls = 0;
    int guard = 0;
    grid_in = G; r8.row_ready = 1'b1; start8 = 1'b1;
    cyc = 0; tick; start8 = 1'b0;
    while (k < 8 && guard < 40) begin
      vectors++;
      if (obs8 !== e8(1, 1, 0, k == 7, 3'(k), 8'(k + 1))) begin
        miscompares++;
        $display("FAIL backpressure beat %0d cyc %0d: got %h expected %h", k, cyc, obs8,
                 e8(1, 1, 0, k == 7, 3'(k), 8'(k + 1)));
      end
      if (k == 2 && stalls < 3) begin
        r8.row_ready = 1'b0; stalls++;
      end else begin
        r8.row_ready = 1'b1;
      end
      tick;
      if (r8.row_ready) k++;
      guard++;
    end
    r8.row_ready = 1'b1;
    vectors++;
    if (obs8 !== e8(0, 1, 1, 0, 3'd7, 8'h08) || cyc != 12) begin
      miscompares++;
      $display("FAIL backpressure done: got %h at cycle %0d expected %h at cycle 12", obs8, cyc,
               e8(0, 1, 1, 0, 3'd7, 8'h08));
    end
    tick;
  endtask

  task automatic test_isolation;
    grid_in = G; r8.row_ready = 1'b1; start8 = 1'b1;
    cyc = 0; tick; start8 = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (c == 2) grid_in = 64'hFFFF_FFFF_FFFF_FFFF;
      vectors++;
      if (obs8 !== e8(1, 1, 0, c == 8, 3'(c - 1), 8'(c))) begin
        miscompares++;
        $display("FAIL isolation beat %0d: got %h expected %h", c, obs8, e8(1, 1, 0, c == 8, 3'(c - 1), 8'(c)));
      end
      tick;
    end
    vectors++;
    if (obs8 !== e8(0, 1, 1, 0, 3'd7, 8'h08)) begin
      miscompares++; $display("FAIL isolation done: got %h expected %h", obs8, e8(0, 1, 1, 0, 3'd7, 8'h08));
    end
    tick;
    grid_in = G;
  endtask

  task automatic test_start_ignored;
    int guard = 0;
    grid_in = G; r8.row_ready = 1'b1; start8 = 1'b1;
    cyc = 0; tick;
    for (int c = 1; c <= 8; c++) begin
      start8 = (c == 3);
      if (c == 3) grid_in = H;
      vectors++;
      if (obs8 !== e8(1, 1, 0, c == 8, 3'(c - 1), 8'(c))) begin
        miscompares++;
        $display("FAIL ignore beat %0d: got %h expected %h", c, obs8, e8(1, 1, 0, c == 8, 3'(c - 1), 8'(c)));
      end
      tick;
    end
    start8 = 1'b1;
    vectors++;
    if (obs8 !== e8(0, 1, 1, 0, 3'd7, 8'h08)) begin
      miscompares++; $display("FAIL ignore done: got %h expected %h", obs8, e8(0, 1, 1, 0, 3'd7, 8'h08));
    end
    tick; start8 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (obs8 !== e8(0, 0, 0, 0, 3'd0, 8'h01)) begin
        miscompares++;
        $display("FAIL ignore idle %0d: got %h expected %h", i, obs8, e8(0, 0, 0, 0, 3'd0, 8'h01));
      end
      tick;
    end
    // Held start: DONE, one IDLE cycle, then the next capture.
    grid_in = G; start8 = 1'b1;
    tick;
    for (int c = 1; c <= 8; c++) begin
      vectors++;
      if (obs8 !== e8(1, 1, 0, c == 8, 3'(c - 1), 8'(c))) begin
        miscompares++;
        $display("FAIL held beat %0d: got %h expected %h", c, obs8, e8(1, 1, 0, c == 8, 3'(c - 1), 8'(c)));
      end
      tick;
    end
    vectors++;
    if (obs8 !== e8(0, 1, 1, 0, 3'd7, 8'h08)) begin
      miscompares++; $display("FAIL held done: got %h expected %h", obs8, e8(0, 1, 1, 0, 3'd7, 8'h08));
    end
    tick;
    grid_in = G2;
    vectors++;
    if (obs8 !== e8(0, 0, 0, 0, 3'd0, 8'h01)) begin
      miscompares++; $display("FAIL held gap: got %h expected %h", obs8, e8(0, 0, 0, 0, 3'd0, 8'h01));
    end
    tick;
    vectors++;
    if (obs8 !== e8(1, 1, 0, 0, 3'd0, 8'h11)) begin
      miscompares++; $display("FAIL held restart: got %h expected %h", obs8, e8(1, 1, 0, 0, 3'd0, 8'h11));
    end
    start8 = 1'b0;
    while (!done8 && guard < 40) begin
      tick; guard++;
    end
    vectors++;
    if (done8 !== 1'b1) begin
      miscompares++; $display("FAIL held drain: done got %b expected 1 within 40 cycles", done8);
    end
    tick;
    grid_in = G;
  endtask

  task automatic test_reset_mid;
    grid_in = G; r8.row_ready = 1'b1; start8 = 1'b1;
    cyc = 0; tick; start8 = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      vectors++;
      if (obs8 !== e8(1, 1, 0, 0, 3'(c - 1), 8'(c))) begin
        miscompares++;
        $display("FAIL abort beat %0d: got %h expected %h", c, obs8, e8(1, 1, 0, 0, 3'(c - 1), 8'(c)));
      end
      if (c < 5) tick;
    end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (obs8 !== e8(0, 0, 0, 0, 3'd0, 8'h00)) begin
        miscompares++;
        $display("FAIL abort after %0d: got %h expected %h", i, obs8, e8(0, 0, 0, 0, 3'd0, 8'h00));
      end
      tick;
    end
    start8 = 1'b1;
    tick; start8 = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      vectors++;
      if (obs8 !== e8(1, 1, 0, c == 8, 3'(c - 1), 8'(c))) begin
        miscompares++;
        $display("FAIL rerun beat %0d: got %h expected %h", c, obs8, e8(1, 1, 0, c == 8, 3'(c - 1), 8'(c)));
      end
      tick;
    end
    vectors++;
    if (obs8 !== e8(0, 1, 1, 0, 3'd7, 8'h08)) begin
      miscompares++; $display("FAIL rerun done: got %h expected %h", obs8, e8(0, 1, 1, 0, 3'd7, 8'h08));
    end
    tick;
  endtask

  task automatic test_wide_rows;
    logic [15:0] exp16 [4];
    exp16[0] = 16'hAAAA; exp16[1] = 16'hBBBB; exp16[2] = 16'hCCCC; exp16[3] = 16'hDDDD;
    grid_in = W; r16.row_ready = 1'b1; start16 = 1'b1;
    tick; start16 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (obs16 !== e16(1, 1, 0, k == 3, 2'(k), exp16[k])) begin
        miscompares++;
        $display("FAIL wide beat %0d: got %h expected %h", k, obs16, e16(1, 1, 0, k == 3, 2'(k), exp16[k]));
      end
      tick;
    end
    vectors++;
    if (obs16 !== e16(0, 1, 1, 0, 2'd3, 16'hDDDD)) begin
      miscompares++; $display("FAIL wide done: got %h expected %h", obs16, e16(0, 1, 1, 0, 2'd3, 16'hDDDD));
    end
    tick;
    vectors++;
    if (obs16 !== e16(0, 0, 0, 0, 2'd0, 16'hAAAA)) begin
      miscompares++; $display("FAIL wide idle: got %h expected %h", obs16, e16(0, 0, 0, 0, 2'd0, 16'hAAAA));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset;
    test_stream;
    test_backpressure;
    test_isolation;
    test_start_ignored;
    test_reset_mid;
    test_wide_rows;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
